// File: rtl/xbar_pkg.sv
// Shared types and width helpers for the stream crossbar (destination decode, arbiter, datapath mux).
// Define XBAR_ARB_PKT_LOCK_EN to hold each output's grant until the last beat of a packet.
package xbar_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Index width for a port count; a single port still needs one bit to exist as a signal.
    function automatic int idx_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

`ifdef XBAR_ARB_PKT_LOCK_EN
    localparam bit PKT_LOCK_EN = 1'b1;
`else
    localparam bit PKT_LOCK_EN = 1'b0;
`endif

endpackage

// File: rtl/xbar_arbiter_rr.sv
// Round-robin arbiter for one crossbar output: IDLE/LOCKED FSM with a selected input and last-winner pointer.
// Release condition follows xbar_pkg::PKT_LOCK_EN (set by XBAR_ARB_PKT_LOCK_EN).
module rr_arbiter
    import xbar_pkg::*;
#(
    parameter int S_DATA_COUNT = 2,
    parameter int IDX_W        = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [S_DATA_COUNT-1:0] req_i,
    input  logic                    valid_i,
    input  logic                    ready_i,
    input  logic                    last_i,
    output logic [IDX_W-1:0]        sel_o,
    output logic                    busy_o,
    output logic                    valid_o
);

    arb_state_e       r_state;
    logic [IDX_W-1:0] r_sel;
    logic [IDX_W-1:0] r_ptr;

    logic             w_found;
    logic [IDX_W-1:0] w_winner;
    logic [IDX_W-1:0] w_cand;
    logic             w_locked;
    logic             w_release;

    // Scan starts one past the previous winner so the last owner has lowest priority.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_cand   = r_ptr;
        for (int k = 1; k <= S_DATA_COUNT; k++) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % S_DATA_COUNT);
            if (!w_found && req_i[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_locked  = (r_state == ARB_LOCKED);
    assign w_release = w_locked && valid_i && ready_i && (PKT_LOCK_EN ? last_i : 1'b1);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_sel   <= '0;
            r_ptr   <= IDX_W'(S_DATA_COUNT - 1);
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_state <= ARB_LOCKED;
                        r_sel   <= w_winner;
                    end
                end
                ARB_LOCKED: begin
                    if (w_release) begin
                        r_state <= ARB_IDLE;
                        r_ptr   <= r_sel;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign sel_o   = r_sel;
    assign busy_o  = w_locked;
    assign valid_o = w_locked && valid_i;

endmodule

// File: rtl/xbar_arbiter.sv
// Per-output arbitration for the stream crossbar: request decode, one rr_arbiter per output, ready fan-back.
// Packet lock is enabled by defining XBAR_ARB_PKT_LOCK_EN; otherwise grants rotate every beat.
module xbar_arbiter
    import xbar_pkg::*;
#(
    parameter  int S_DATA_COUNT = 2,
    parameter  int M_DATA_COUNT = 3,
    localparam int T_DEST_WIDTH = idx_width(M_DATA_COUNT),
    localparam int S_IDX_WIDTH  = idx_width(S_DATA_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid_i [S_DATA_COUNT-1:0],
    input  logic [T_DEST_WIDTH-1:0] s_dest_i  [S_DATA_COUNT-1:0],
    input  logic                    s_last_i  [S_DATA_COUNT-1:0],
    output logic                    s_ready_o [S_DATA_COUNT-1:0],
    input  logic                    m_ready_i [M_DATA_COUNT-1:0],
    output logic                    m_valid_o [M_DATA_COUNT-1:0],
    output logic [S_IDX_WIDTH-1:0]  m_sel_o   [M_DATA_COUNT-1:0],
    output logic                    m_busy_o  [M_DATA_COUNT-1:0]
);

    logic w_dest_ok [S_DATA_COUNT-1:0];

    // Out-of-range destinations are dropped here so they can never reach any arbiter.
    always_comb begin
        for (int s = 0; s < S_DATA_COUNT; s++) begin
            w_dest_ok[s] = (int'(s_dest_i[s]) < M_DATA_COUNT);
        end
    end

    for (genvar m = 0; m < M_DATA_COUNT; m++) begin : g_out
        logic [S_DATA_COUNT-1:0] w_req;
        logic                    w_sel_valid;
        logic                    w_sel_last;

        always_comb begin
            for (int s = 0; s < S_DATA_COUNT; s++) begin
                w_req[s] = s_valid_i[s] && w_dest_ok[s] && (s_dest_i[s] == T_DEST_WIDTH'(m));
            end
        end

        assign w_sel_valid = s_valid_i[m_sel_o[m]];
        assign w_sel_last  = s_last_i[m_sel_o[m]];

        rr_arbiter #(
            .S_DATA_COUNT (S_DATA_COUNT),
            .IDX_W        (S_IDX_WIDTH)
        ) u_rr_arbiter (
            .clk     (clk),
            .rst_n   (rst_n),
            .req_i   (w_req),
            .valid_i (w_sel_valid),
            .ready_i (m_ready_i[m]),
            .last_i  (w_sel_last),
            .sel_o   (m_sel_o[m]),
            .busy_o  (m_busy_o[m]),
            .valid_o (m_valid_o[m])
        );
    end

    // An input has a single destination, so at most one locked output can be driving its ready.
    always_comb begin
        for (int s = 0; s < S_DATA_COUNT; s++) begin
            s_ready_o[s] = 1'b0;
            for (int m = 0; m < M_DATA_COUNT; m++) begin
                if (m_busy_o[m] && (m_sel_o[m] == S_IDX_WIDTH'(s))) begin
                    s_ready_o[s] = s_ready_o[s] | m_ready_i[m];
                end
            end
        end
    end

endmodule

// File: tb/tb_xbar_arbiter.sv
// Self-checking bench for xbar_arbiter: owner/last-winner reference model plus directed scenarios.
// Expectations follow XBAR_ARB_PKT_LOCK_EN the same way the design does.
module tb_xbar_arbiter;

    localparam int S   = 2;
    localparam int M   = 3;
    localparam int TDW = 2;
    localparam int IW  = 1;

`ifdef XBAR_ARB_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic           s_valid_i [S-1:0];
    logic [TDW-1:0] s_dest_i  [S-1:0];
    logic           s_last_i  [S-1:0];
    logic           s_ready_o [S-1:0];
    logic           m_ready_i [M-1:0];
    logic           m_valid_o [M-1:0];
    logic [IW-1:0]  m_sel_o   [M-1:0];
    logic           m_busy_o  [M-1:0];

    int checks   = 0;
    int failures = 0;

    xbar_arbiter #(
        .S_DATA_COUNT (S),
        .M_DATA_COUNT (M)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid_i (s_valid_i),
        .s_dest_i  (s_dest_i),
        .s_last_i  (s_last_i),
        .s_ready_o (s_ready_o),
        .m_ready_i (m_ready_i),
        .m_valid_o (m_valid_o),
        .m_sel_o   (m_sel_o),
        .m_busy_o  (m_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [M-1:0] busy_v;
    logic [M-1:0] mvalid_v;
    logic [S-1:0] sready_v;

    always_comb begin
        for (int m = 0; m < M; m++) begin
            busy_v[m]   = m_busy_o[m];
            mvalid_v[m] = m_valid_o[m];
        end
        for (int s = 0; s < S; s++) sready_v[s] = s_ready_o[s];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which input owns each output (-1 = free), who won last, last select shown.
    int owner  [M];
    int last_w [M];
    int msel   [M];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < M; m++) begin
                owner[m]  = -1;
                last_w[m] = S - 1;
                msel[m]   = 0;
            end
        end else begin
            for (int m = 0; m < M; m++) begin
                if (owner[m] >= 0) begin
                    if (s_valid_i[owner[m]] && m_ready_i[m] && (!LOCK || s_last_i[owner[m]])) begin
                        last_w[m] = owner[m];
                        owner[m]  = -1;
                    end
                end else begin
                    for (int d = 1; d <= S; d++) begin
                        int s;
                        s = (last_w[m] + d) % S;
                        if (owner[m] < 0 && s_valid_i[s] && int'(s_dest_i[s]) == m) begin
                            owner[m] = s;
                            msel[m]  = s;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [M-1:0] e_busy;
            logic [M-1:0] e_valid;
            logic [S-1:0] e_ready;
            e_busy  = '0;
            e_valid = '0;
            e_ready = '0;
            for (int m = 0; m < M; m++) begin
                if (owner[m] >= 0) begin
                    e_busy[m]  = 1'b1;
                    e_valid[m] = s_valid_i[owner[m]];
                    if (m_ready_i[m]) e_ready[owner[m]] = 1'b1;
                end
            end
            check("mdl_busy", 32'(busy_v), 32'(e_busy));
            check("mdl_m_valid", 32'(mvalid_v), 32'(e_valid));
            check("mdl_s_ready", 32'(sready_v), 32'(e_ready));
            for (int m = 0; m < M; m++) check($sformatf("mdl_sel%0d", m), 32'(m_sel_o[m]), 32'(msel[m]));
        end
    end

    task automatic clear_inputs();
        for (int s = 0; s < S; s++) begin
            s_valid_i[s] = 1'b0;
            s_dest_i[s]  = '0;
            s_last_i[s]  = 1'b0;
        end
        for (int m = 0; m < M; m++) m_ready_i[m] = 1'b1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy_v), 0);
        check("rst_m_valid", 32'(mvalid_v), 0);
        check("rst_s_ready", 32'(sready_v), 0);
        check("rst_sel1", 32'(m_sel_o[1]), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Streams n0 beats from in0 and n1 beats from in1 into out1, logging the grant order;
    // after stall_at accepted beats, out1 ready drops for 5 cycles.
    logic [15:0] order_bits;
    int          order_cnt;

    task automatic run_pkts(input int n0, input int n1, input int stall_at);
        int rem0, rem1, stall_left, cyc;
        bit stall_done, hs0, hs1;
        rem0 = n0; rem1 = n1; stall_left = 0; stall_done = 1'b0; cyc = 0;
        order_bits = '0; order_cnt = 0;
        @(posedge clk);
        #1;
        s_dest_i[0] = 2'd1; s_dest_i[1] = 2'd1;
        s_valid_i[0] = (rem0 > 0); s_last_i[0] = (rem0 == 1);
        s_valid_i[1] = (rem1 > 0); s_last_i[1] = (rem1 == 1);
        while ((rem0 > 0 || rem1 > 0) && cyc < 80) begin
            @(negedge clk);
            hs0 = s_valid_i[0] && s_ready_o[0];
            hs1 = s_valid_i[1] && s_ready_o[1];
            if (m_valid_o[1] && m_ready_i[1]) begin
                order_bits = {order_bits[14:0], m_sel_o[1]};
                order_cnt++;
            end
            if (!m_ready_i[1]) check("stall_s_ready0", 32'(s_ready_o[0]), 0);
            @(posedge clk);
            #1;
            cyc++;
            if (hs0) rem0--;
            if (hs1) rem1--;
            s_valid_i[0] = (rem0 > 0); s_last_i[0] = (rem0 == 1);
            s_valid_i[1] = (rem1 > 0); s_last_i[1] = (rem1 == 1);
            if (!m_ready_i[1]) begin
                stall_left--;
                if (stall_left == 0) m_ready_i[1] = 1'b1;
            end else if (!stall_done && order_cnt == stall_at) begin
                m_ready_i[1] = 1'b0;
                stall_left   = 5;
                stall_done   = 1'b1;
            end
        end
        check("pkts_done", 32'(rem0 + rem1), 0);
        clear_inputs();
    endtask

    initial begin
        logic [5:0] busy_hist, sel_hist;
        rst_n = 1'b1;
        clear_inputs();
        apply_reset();

        // Two 1-beat requesters on out1: grants alternate with an idle cycle between.
        @(posedge clk);
        #1;
        s_valid_i[0] = 1'b1; s_dest_i[0] = 2'd1; s_last_i[0] = 1'b1;
        s_valid_i[1] = 1'b1; s_dest_i[1] = 2'd1; s_last_i[1] = 1'b1;
        busy_hist = '0; sel_hist = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            busy_hist = {busy_hist[4:0], m_busy_o[1]};
            sel_hist  = {sel_hist[4:0], m_sel_o[1]};
        end
        check("alt_busy_pattern", 32'(busy_hist), 32'(6'b010101));
        check("alt_sel_pattern", 32'(sel_hist), 32'(6'b000110));

        // Disjoint destinations lock concurrently one cycle after the request.
        apply_reset();
        @(posedge clk);
        #1;
        s_valid_i[0] = 1'b1; s_dest_i[0] = 2'd0; s_last_i[0] = 1'b0;
        s_valid_i[1] = 1'b1; s_dest_i[1] = 2'd2; s_last_i[1] = 1'b0;
        @(negedge clk);
        check("disj_busy_n", 32'(busy_v), 0);
        @(negedge clk);
        check("disj_busy_n1", 32'(busy_v), 32'(3'b101));
        check("disj_valid_n1", 32'(mvalid_v), 32'(3'b101));
        check("disj_ready_n1", 32'(sready_v), 32'(2'b11));
        check("disj_sel2", 32'(m_sel_o[2]), 1);
        repeat (6) @(negedge clk);
        clear_inputs();

        // Two 4-beat packets contend for out1.
        apply_reset();
        run_pkts(4, 4, -1);
        check("contend_beats", 32'(order_cnt), 8);
        check("contend_order", 32'(order_bits[7:0]), LOCK ? 32'h0F : 32'h55);

        // Back-pressure on out1 mid-packet: beat held, no loss.
        apply_reset();
        run_pkts(4, 0, 1);
        check("stall_beats", 32'(order_cnt), 4);
        check("stall_order", 32'(order_bits[3:0]), 0);

        // Out-of-range destination is never granted.
        apply_reset();
        @(posedge clk);
        #1;
        s_valid_i[1] = 1'b1; s_dest_i[1] = 2'd3; s_last_i[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bad_dest_ready", 32'(s_ready_o[1]), 0);
            check("bad_dest_valid", 32'(mvalid_v), 0);
        end
        clear_inputs();

        // Reset mid-packet drops the lock at once; in0 wins the next contended grant.
        apply_reset();
        @(posedge clk);
        #1;
        s_valid_i[0] = 1'b1; s_dest_i[0] = 2'd1; s_last_i[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy_before", 32'(m_busy_o[1]), 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy_v), 0);
        check("mid_rst_valid", 32'(mvalid_v), 0);
        check("mid_rst_ready", 32'(sready_v), 0);
        check("mid_rst_sel1", 32'(m_sel_o[1]), 0);
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        run_pkts(1, 1, -1);
        check("post_rst_order", 32'(order_bits[1:0]), 32'(2'b01));

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
